// File: rtl/flp2int_seq.sv
// Sequential binary32 -> signed int32 converter, round-to-nearest-even,
// with a bit-serial alignment shifter between two valid/ready handshakes.
module flp2int_seq #(
    parameter int Bits = 32
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  logic [Bits-1:0] iA,
    output logic            oValid,
    input  logic            iReady,
    output logic [Bits-1:0] oZ,
    output logic            oInvalid,
    output logic            oInexact
);

    typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] op;
    logic [31:0] mag;
    logic        grd;
    logic        stk;
    logic        left;
    logic [4:0]  cnt;
    logic        ovr;
    logic [31:0] ovr_z;
    logic        ovr_inv;
    logic        ovr_inx;

    logic        sgn;
    logic [7:0]  exp_f;
    logic [22:0] frac;
    logic [23:0] man;
    logic [4:0]  shift_n;

    assign sgn     = op[31];
    assign exp_f   = op[30:23];
    assign frac    = op[22:0];
    assign man     = {|exp_f, frac};
    // Only meaningful for exponents 126..157; specials never use it.
    assign shift_n = (exp_f >= 8'd150) ? 5'(exp_f - 8'd150) : 5'(8'd150 - exp_f);

    function automatic logic signed [31:0] round_rne(input logic [31:0] m,
                                                     input logic g,
                                                     input logic st,
                                                     input logic s);
        logic        up;
        logic [31:0] r;
        up = g & (st | m[0]);
        r  = m + {31'd0, up};
        return s ? -$signed(r) : $signed(r);
    endfunction

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            oReady   <= 1'b1;
            oValid   <= 1'b0;
            oZ       <= '0;
            oInvalid <= 1'b0;
            oInexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        op     <= iA;
                        oReady <= 1'b0;
                        state  <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    ovr     <= 1'b1;
                    ovr_inv <= 1'b0;
                    ovr_inx <= 1'b0;
                    ovr_z   <= 32'd0;
                    mag     <= {8'd0, man};
                    grd     <= 1'b0;
                    stk     <= 1'b0;
                    left    <= 1'b0;
                    cnt     <= 5'd0;
                    state   <= ROUND;
                    if (exp_f == 8'd255 && frac != 23'd0) begin
                        ovr_z   <= 32'h7FFF_FFFF;
                        ovr_inv <= 1'b1;
                    end else if (exp_f == 8'd255 ||
                                 (exp_f >= 8'd158 && op != 32'hCF00_0000)) begin
                        ovr_z   <= sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        ovr_inv <= 1'b1;
                    end else if (exp_f >= 8'd158) begin
                        ovr_z   <= 32'h8000_0000;
                    end else if (exp_f < 8'd126) begin
                        ovr_inx <= (exp_f != 8'd0) || (frac != 23'd0);
                    end else begin
                        ovr   <= 1'b0;
                        left  <= (exp_f >= 8'd150);
                        cnt   <= shift_n;
                        state <= (shift_n != 5'd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    // Right shifts feed the guard bit and fold the old guard into sticky.
                    if (left) begin
                        mag <= mag << 1;
                    end else begin
                        stk <= stk | grd;
                        grd <= mag[0];
                        mag <= mag >> 1;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= ROUND;
                end
                ROUND: begin
                    if (ovr) begin
                        oZ       <= ovr_z;
                        oInvalid <= ovr_inv;
                        oInexact <= ovr_inx;
                    end else begin
                        oZ       <= round_rne(mag, grd, stk, sgn);
                        oInvalid <= 1'b0;
                        oInexact <= grd | stk;
                    end
                    oValid <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    oValid <= 1'b0;
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flp2int_seq.sv
// Table-driven bench for flp2int_seq with a scoreboard queue of expected
// results plus hand sequences for backpressure and mid-shift reset.
module tb_flp2int_seq;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a;
    logic        z_valid;
    logic        z_ready;
    logic [31:0] z;
    logic        invalid;
    logic        inexact;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic        inv;
        logic        inx;
        int          lat;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    flp2int_seq #(.Bits(32)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iValid  (a_valid),
        .oReady  (a_ready),
        .iA      (a),
        .oValid  (z_valid),
        .iReady  (z_ready),
        .oZ      (z),
        .oInvalid(invalid),
        .oInexact(inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Launch one operand (edge 0) without waiting for the result.
    task automatic launch(input logic [31:0] val);
        check("ready_before_launch", {31'd0, a_ready}, 32'd1);
        a       = val;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Wait for the result, compare it to the scoreboard head, then handshake it out.
    task automatic collect(input string name, input int stall);
        int   lat;
        exp_t e;
        lat = 0;
        while (!z_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({name, "_latency"}, lat, e.lat);
        check({name, "_z"}, z, e.z);
        check({name, "_invalid"}, {31'd0, invalid}, {31'd0, e.inv});
        check({name, "_inexact"}, {31'd0, inexact}, {31'd0, e.inx});
        for (int i = 0; i < stall; i++) begin
            a       = 32'h4000_0000;
            a_valid = (i == 2);
            @(posedge clk);
            #1;
            check({name, "_hold_z"}, z, e.z);
            check({name, "_hold_flags"}, {30'd0, invalid, inexact}, {30'd0, e.inv, e.inx});
            check({name, "_hold_valid"}, {31'd0, z_valid}, 32'd1);
            check({name, "_hold_notready"}, {31'd0, a_ready}, 32'd0);
        end
        a_valid = 1'b0;
        z_ready = 1'b1;
        @(posedge clk);
        #1;
        z_ready = 1'b0;
        check({name, "_valid_dropped"}, {31'd0, z_valid}, 32'd0);
        check({name, "_ready_back"}, {31'd0, a_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name, input int stall);
        exp_t e;
        e.z   = v.z;
        e.inv = v.inv;
        e.inx = v.inx;
        e.lat = v.lat;
        sb.push_back(e);
        launch(v.a);
        collect(name, stall);
    endtask

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
        vecs[1]  = '{32'h4B3C_614E, 32'h00BC_614E, 1'b0, 1'b0, 2};
        vecs[2]  = '{32'h4EC0_0000, 32'h6000_0000, 1'b0, 1'b0, 9};
        vecs[3]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 24};
        vecs[4]  = '{32'h4060_0000, 32'h0000_0004, 1'b0, 1'b1, 24};
        vecs[5]  = '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 25};
        vecs[6]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 26};
        vecs[7]  = '{32'h3F00_0001, 32'h0000_0001, 1'b0, 1'b1, 26};
        vecs[8]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
        vecs[9]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[10] = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[11] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
        vecs[12] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
        vecs[13] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[14] = '{32'hC040_0000, 32'hFFFF_FFFD, 1'b0, 1'b0, 24};
        vecs[15] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[16] = '{32'h3E80_0000, 32'h0000_0000, 1'b0, 1'b1, 2};

        rst     = 1'b1;
        a_valid = 1'b0;
        z_ready = 1'b0;
        a       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", {31'd0, a_ready}, 32'd1);
        check("reset_valid", {31'd0, z_valid}, 32'd0);
        check("reset_z", z, 32'd0);
        check("reset_flags", {30'd0, invalid, inexact}, 32'd0);

        for (int i = 0; i < 17; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i), 0);

        // Backpressure: result held 5 cycles with a stray operand pulse.
        run_vec(vecs[3], "backpressure", 5);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_stray_accept", {31'd0, a_ready}, 32'd1);
        end

        // Reset in the middle of shifting 1.0, then a fresh 2.0.
        launch(32'h3F80_0000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_valid", {31'd0, z_valid}, 32'd0);
        check("midreset_ready", {31'd0, a_ready}, 32'd1);
        run_vec('{32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0, 24}, "after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
